// File: rtl/moxie_pkg.sv
// Shared constants and types for the moxie register scoreboard.
package moxie_pkg;
  localparam int NREGS_DEF    = 16;
  localparam int IDX_W        = $clog2(NREGS_DEF);
  localparam int MAX_PEND_DEF = 3;
  localparam int PEND_W       = $clog2(MAX_PEND_DEF + 1);

  typedef logic [PEND_W-1:0] pend_cnt_t;
endpackage

// File: rtl/cpu_scoreboard_entry.sv
// One register's outstanding-write counter. The 'one' output exists only
// when MOXIE_SCOREBOARD_BYPASS_EN is defined (it feeds the bypass check).
module cpu_scoreboard_entry
  import moxie_pkg::*;
#(
  parameter int MAX_PEND = MAX_PEND_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic dec,
  input  logic clr,
  output logic busy,
  output logic full,
  output logic err
`ifdef MOXIE_SCOREBOARD_BYPASS_EN
  , output logic one
`endif
);
  localparam int CW = $clog2(MAX_PEND + 1);

  logic [CW-1:0] cnt;

  // Simultaneous inc and dec cancel; dec at zero is an error, not an underflow.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                        cnt <= '0;
    else if (clr)                      cnt <= '0;
    else if (inc && !dec && !full)     cnt <= cnt + CW'(1);
    else if (dec && !inc && busy)      cnt <= cnt - CW'(1);

  assign busy = cnt != '0;
  assign full = cnt == CW'(MAX_PEND);
  assign err  = dec && !busy && !clr;
`ifdef MOXIE_SCOREBOARD_BYPASS_EN
  assign one  = cnt == CW'(1);
`endif
endmodule

// File: rtl/cpu_scoreboard.sv
// Register scoreboard: RAW/saturation issue gating, writeback retire, flush.
// Define MOXIE_SCOREBOARD_BYPASS_EN to let reads of a last-pending register
// being retired this cycle issue with a forward indication.
module cpu_scoreboard
  import moxie_pkg::*;
#(
  parameter int NREGS       = NREGS_DEF,
  parameter int NREAD       = 2,
  parameter int MAX_PEND    = MAX_PEND_DEF,
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   issue_valid_i,
  output logic                   issue_ready_o,
  input  logic [NREAD-1:0]       rd_en_i,
  input  logic [NREAD*IDX_W-1:0] rd_idx_i,
  input  logic                   wr_en_i,
  input  logic [IDX_W-1:0]       wr_idx_i,
  input  logic                   wb_valid_i,
  input  logic [IDX_W-1:0]       wb_idx_i,
  input  logic                   flush_i,
  output logic [NREGS-1:0]       busy_o,
  output logic [NREAD-1:0]       fwd_o,
  output logic                   stall_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o,
  output logic                   err_o
);
  logic [NREGS-1:0]            wr_hit, wb_hit, full, err_hit, byp_mask;
  logic [NREAD-1:0][NREGS-1:0] rd_hit;
  logic [NREAD-1:0]            raw;
  logic                        sat, accept;

  for (genvar r = 0; r < NREGS; r++) begin : g_reg
    assign wr_hit[r] = wr_en_i    && (wr_idx_i == IDX_W'(r));
    assign wb_hit[r] = wb_valid_i && (wb_idx_i == IDX_W'(r));
  end

`ifdef MOXIE_SCOREBOARD_BYPASS_EN
  logic [NREGS-1:0] one;
  assign byp_mask = one & wb_hit;
`else
  assign byp_mask = '0;
`endif

  for (genvar r = 0; r < NREGS; r++) begin : g_ent
    cpu_scoreboard_entry #(.MAX_PEND(MAX_PEND)) u_entry (
      .clk  (clk_i),
      .rst_n(rst_i),
      .inc  (accept && wr_hit[r]),
      .dec  (wb_hit[r]),
      .clr  (flush_i),
      .busy (busy_o[r]),
      .full (full[r]),
      .err  (err_hit[r])
`ifdef MOXIE_SCOREBOARD_BYPASS_EN
      , .one(one[r])
`endif
    );
  end

  for (genvar p = 0; p < NREAD; p++) begin : g_rd
    logic [IDX_W-1:0] idx;
    assign idx = rd_idx_i[p*IDX_W +: IDX_W];
    for (genvar r = 0; r < NREGS; r++) begin : g_hit
      assign rd_hit[p][r] = idx == IDX_W'(r);
    end
    assign raw[p] = rd_en_i[p] && |(rd_hit[p] & busy_o & ~byp_mask);
`ifdef MOXIE_SCOREBOARD_BYPASS_EN
    assign fwd_o[p] = rd_en_i[p] && |(rd_hit[p] & byp_mask);
`else
    assign fwd_o[p] = 1'b0;
`endif
  end

  // A full destination may still issue if the same register retires this cycle.
  assign sat           = |(wr_hit & full & ~wb_hit);
  assign issue_ready_o = rst_i && !flush_i && !(|raw) && !sat;
  assign accept        = issue_valid_i && issue_ready_o;
  assign stall_o       = issue_valid_i && !issue_ready_o;

  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i)          err_o <= 1'b0;
    else if (|err_hit)   err_o <= 1'b1;

  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i)                          stall_cnt_o <= '0;
    else if (stall_o && !(&stall_cnt_o)) stall_cnt_o <= stall_cnt_o + STALL_CNT_W'(1);
endmodule

// File: tb/tb_cpu_scoreboard.sv
// Randomized + directed bench for cpu_scoreboard against a counter-array model.
module tb_cpu_scoreboard;
  import moxie_pkg::*;
  localparam int NREGS = 16, NREAD = 2, MAXP = 3, SCW = 4;

  logic             clk_i = 0, rst_i = 0;
  logic             issue_valid_i = 0, wr_en_i = 0, wb_valid_i = 0, flush_i = 0;
  logic [1:0]       rd_en_i = 0;
  logic [7:0]       rd_idx_i = 0;
  logic [3:0]       wr_idx_i = 0, wb_idx_i = 0;
  logic             issue_ready_o, stall_o, err_o;
  logic [NREGS-1:0] busy_o;
  logic [1:0]       fwd_o;
  logic [SCW-1:0]   stall_cnt_o;

  cpu_scoreboard #(.NREGS(NREGS), .NREAD(NREAD), .MAX_PEND(MAXP), .STALL_CNT_W(SCW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .rd_en_i(rd_en_i), .rd_idx_i(rd_idx_i), .wr_en_i(wr_en_i), .wr_idx_i(wr_idx_i),
    .wb_valid_i(wb_valid_i), .wb_idx_i(wb_idx_i), .flush_i(flush_i), .busy_o(busy_o),
    .fwd_o(fwd_o), .stall_o(stall_o), .stall_cnt_o(stall_cnt_o), .err_o(err_o));

  always #5 clk_i = ~clk_i;

  int n_tests = 0, n_fail = 0;
  int cnt[NREGS];
  bit err_m;
  int sc_m;
  bit byp_en;
  logic       last_rdy;
  logic [1:0] last_fwd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    foreach (cnt[r]) cnt[r] = 0;
    err_m = 0;
    sc_m  = 0;
  endtask

  // One cycle: drive, check against model, then advance the model.
  task automatic step(input bit v, input bit [1:0] re, input int i0, input int i1,
                      input bit we, input int wi, input bit wbv, input int wbi, input bit fl);
    bit rdy, acc;
    bit [1:0] fw;
    bit [NREGS-1:0] bz;
    int idx[2];
    @(negedge clk_i);
    issue_valid_i = v; rd_en_i = re; rd_idx_i = {IDX_W'(i1), IDX_W'(i0)};
    wr_en_i = we; wr_idx_i = IDX_W'(wi); wb_valid_i = wbv; wb_idx_i = IDX_W'(wbi); flush_i = fl;
    #1;
    idx[0] = i0; idx[1] = i1;
    rdy = !fl;
    fw  = '0;
    for (int p = 0; p < 2; p++)
      if (re[p] && cnt[idx[p]] > 0) begin
        if (byp_en && cnt[idx[p]] == 1 && wbv && wbi == idx[p]) fw[p] = 1;
        else rdy = 0;
      end
    if (we && cnt[wi] == MAXP && !(wbv && wbi == wi)) rdy = 0;
    for (int r = 0; r < NREGS; r++) bz[r] = cnt[r] != 0;
    chk("busy", busy_o, bz);
    chk("ready", issue_ready_o, rdy);
    chk("fwd", fwd_o, fw);
    chk("stall", stall_o, v && !rdy);
    chk("stall_cnt", stall_cnt_o, sc_m);
    chk("err", err_o, err_m);
    last_rdy = issue_ready_o;
    last_fwd = fwd_o;
    acc = v && rdy;
    if (v && !rdy && sc_m < (1 << SCW) - 1) sc_m++;
    if (fl) foreach (cnt[r]) cnt[r] = 0;
    else begin
      if (wbv && cnt[wbi] == 0) err_m = 1;
      if (!(acc && we && wbv && wi == wbi)) begin
        if (acc && we) cnt[wi]++;
        if (wbv && cnt[wbi] > 0) cnt[wbi]--;
      end
    end
  endtask

  // Reset asserted mid-cycle, away from any clock edge.
  task automatic do_reset();
    @(negedge clk_i);
    #2;
    rst_i = 0;
    issue_valid_i = 0; rd_en_i = 0; wr_en_i = 0; wb_valid_i = 0; flush_i = 0;
    #1;
    chk("arst_busy", busy_o, 0);
    chk("arst_ready", issue_ready_o, 0);
    chk("arst_err", err_o, 0);
    chk("arst_scnt", stall_cnt_o, 0);
    model_clear();
    @(negedge clk_i);
    rst_i = 1;
  endtask

  initial begin
    int pend[$];
    int wbi;
`ifdef MOXIE_SCOREBOARD_BYPASS_EN
    byp_en = 1;
`else
    byp_en = 0;
`endif
    model_clear();
    #3;
    chk("rst_busy", busy_o, 0);
    chk("rst_ready", issue_ready_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_scnt", stall_cnt_o, 0);
    chk("rst_fwd", fwd_o, 0);
    @(negedge clk_i);
    rst_i = 1;

    // RAW stall on r3
    step(1, 2'b00, 0, 0, 1, 3, 0, 0, 0);
    step(1, 2'b01, 3, 0, 0, 0, 0, 0, 0);
    chk("raw_ready", last_rdy, 0);
    @(posedge clk_i); #1;
    chk("raw_scnt", stall_cnt_o, 1);

    // r3 count 1, retired this cycle while being read
    step(1, 2'b01, 3, 0, 0, 0, 1, 3, 0);
    chk("byp_ready", last_rdy, byp_en);
    chk("byp_fwd0", last_fwd[0], byp_en);

    // saturation on r5
    for (int k = 0; k < 3; k++) step(1, 2'b00, 0, 0, 1, 5, 0, 0, 0);
    step(1, 2'b00, 0, 0, 1, 5, 0, 0, 0);
    chk("sat_ready", last_rdy, 0);
    step(1, 2'b00, 0, 0, 1, 5, 1, 5, 0);
    chk("sat_wb_ready", last_rdy, 1);
    step(1, 2'b00, 0, 0, 1, 5, 0, 0, 0);
    chk("sat_still_full", last_rdy, 0);

    // writeback to idle register
    step(0, 2'b00, 0, 0, 0, 0, 1, 7, 0);
    @(posedge clk_i); #1;
    chk("err_set", err_o, 1);
    step(0, 2'b00, 0, 0, 0, 0, 0, 0, 0);

    // flush beats simultaneous issue
    step(1, 2'b00, 0, 0, 1, 1, 0, 0, 0);
    step(1, 2'b00, 0, 0, 1, 2, 0, 0, 0);
    step(1, 2'b00, 0, 0, 1, 4, 0, 0, 1);
    chk("flush_ready", last_rdy, 0);
    @(posedge clk_i); #1;
    chk("flush_busy", busy_o, 0);

    // async reset with r1,r2 pending
    step(1, 2'b00, 0, 0, 1, 1, 0, 0, 0);
    step(1, 2'b00, 0, 0, 1, 2, 0, 0, 0);
    @(posedge clk_i); #1;
    chk("pre_arst_busy", busy_o, 16'h0006);
    do_reset();

    for (int c = 0; c < 2500; c++) begin
      if (c % 500 == 499) do_reset();
      else begin
        pend.delete();
        for (int r = 0; r < 8; r++) if (cnt[r] > 0) pend.push_back(r);
        wbi = (pend.size() > 0 && $urandom_range(9) != 0) ?
              pend[$urandom_range(pend.size() - 1)] : int'($urandom_range(7));
        step($urandom_range(3) != 0, 2'($urandom), $urandom_range(7), $urandom_range(7),
             $urandom_range(1) == 1, $urandom_range(7), $urandom_range(2) == 0, wbi,
             $urandom_range(39) == 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
